// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, sequencer state encoding and program-counter control codes.
// Used by the sequencer, the PC and the datapath.
package isa_pkg;

  typedef enum logic [3:0] {
    OpNop   = 4'h0,
    OpAlu   = 4'h1,
    OpLoad  = 4'h2,
    OpStore = 4'h3,
    OpJump  = 4'h4,
    OpHalt  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StDecode,
    StExec,
    StMem,
    StJump,
    StHalt
  } seq_state_e;

  localparam logic [1:0] PcHold = 2'b00;
  localparam logic [1:0] PcInc  = 2'b01;
  localparam logic [1:0] PcJump = 2'b10;

  function automatic logic is_legal(logic [3:0] op);
    case (op)
      OpNop, OpAlu, OpLoad, OpStore, OpJump, OpHalt: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/handshake bundle between the instruction sequencer and the rest of the core.
// The sequencer uses the master view; PC, IRAM, data memory and datapath use the slave view.
interface instr_sequencer_if;

  logic        start;
  logic [15:0] iram_data;
  logic        mem_ready;
  logic [1:0]  pc_control;
  logic [15:0] instruction;
  logic        alu_en;
  logic        mem_rd;
  logic        mem_wr;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  modport master (
    input  start, iram_data, mem_ready,
    output pc_control, instruction, alu_en, mem_rd, mem_wr, busy, halted, fault, retired
  );

  modport slave (
    output start, iram_data, mem_ready,
    input  pc_control, instruction, alu_en, mem_rd, mem_wr, busy, halted, fault, retired
  );

endinterface

// File: rtl/mem_watchdog.sv
// Data-memory wait watchdog: counts unanswered MEM cycles and flags the one that
// reaches MEM_TIMEOUT so the sequencer can abandon the access in that same cycle.
module mem_watchdog #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd200
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of earlier unanswered cycles, so this is the MEM_TIMEOUT-th one
  assign expired = count_en && (count_q == (MEM_TIMEOUT - 8'd1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/latch/decode/execute control with a memory
// wait watchdog, sticky fault flag and saturating retired-instruction counter.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = 8'd200
) (
  input logic                clock,
  input logic                reset_n,
  instr_sequencer_if.master  bus
);

  seq_state_e  state_q, state_d;
  logic [15:0] instruction_q;
  logic        fault_q, fault_d;
  logic [15:0] retired_q, retired_d;
  logic [3:0]  opcode;
  logic        timeout;
  logic        retire;

  assign opcode = instruction_q[15:12];

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (state_q != StMem),
    .count_en ((state_q == StMem) && !bus.mem_ready),
    .expired  (timeout)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      instruction_q <= '0;
      fault_q       <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      if (state_q == StLatch) begin
        instruction_q <= bus.iram_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    fault_d = fault_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StFetch;
      StFetch:  state_d = StLatch;
      StLatch:  state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpAlu:          state_d = StExec;
          OpLoad, OpStore: state_d = StMem;
          OpJump:         state_d = StJump;
          OpHalt: begin
            state_d = StHalt;
            retire  = 1'b1;
          end
          default: begin
            // NOP and illegal opcodes both retire straight from decode
            state_d = StFetch;
            retire  = 1'b1;
            if (!is_legal(opcode)) fault_d = 1'b1;
          end
        endcase
      end
      StExec: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMem: begin
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end
      end
      StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
    retired_d = (retire && (retired_q != 16'hFFFF)) ? retired_q + 16'd1 : retired_q;
  end

  always_comb begin
    bus.pc_control = PcHold;
    bus.alu_en     = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    unique case (state_q)
      StLatch: bus.pc_control = PcInc;
      StExec:  bus.alu_en     = 1'b1;
      StMem: begin
        bus.mem_rd = (opcode == OpLoad);
        bus.mem_wr = (opcode == OpStore);
      end
      StJump:  bus.pc_control = PcJump;
      default: ;
    endcase
    bus.busy        = (state_q != StIdle) && (state_q != StHalt);
    bus.halted      = (state_q == StHalt);
    bus.fault       = fault_q;
    bus.retired     = retired_q;
    bus.instruction = instruction_q;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd200, max cycles waiting on mem_ready before fault.
REQ-002 SHALL have ports:
  clock  input  1  rising-edge system clock
  reset_n  input  1  synchronous active-low reset
  start  input  1  level; leaves IDLE when high
  iram_data  input  16  instruction word from instruction RAM (registered read, valid 1 cycle after address change)
  mem_ready  input  1  data-memory access complete
  pc_control  output  2  00 hold, 01 increment, 10 jump; drives program counter
  instruction  output  16  latched instruction register; feeds PC jump fields [11:8]/[7:0] and datapath
  alu_en  output  1  one-cycle datapath execute strobe
  mem_rd  output  1  data-memory read request
  mem_wr  output  1  data-memory write request
  busy  output  1  high in every state except IDLE and HALT
  halted  output  1  high in HALT
  fault  output  1  sticky: memory timeout or illegal opcode
  retired  output  16  count of completed instructions

Function
REQ-003 SHALL decode opcode = instruction[15:12]: 0x0 NOP, 0x1 ALU, 0x2 LOAD, 0x3 STORE, 0x4 JUMP, 0xF HALT; all others illegal.
REQ-004 SHALL implement states IDLE, FETCH, LATCH, DECODE, EXEC, MEM, JUMP, HALT.
REQ-005 IDLE: outputs deasserted; start=1 -> FETCH next cycle.
REQ-006 FETCH: wait one cycle for iram_data; -> LATCH.
REQ-007 LATCH: instruction <= iram_data; pc_control=01 this cycle only; -> DECODE.
REQ-008 DECODE: NOP -> FETCH; ALU -> EXEC; LOAD/STORE -> MEM; JUMP -> JUMP; HALT -> HALT; illegal -> set fault, -> FETCH (treated as NOP).
REQ-009 EXEC: alu_en=1 for exactly one cycle; -> FETCH.
REQ-010 MEM: mem_rd (LOAD) or mem_wr (STORE) held high every MEM cycle until mem_ready sampled high; then -> FETCH with requests low next cycle.
REQ-011 MEM: 8-bit wait counter cleared on entry; if counter reaches MEM_TIMEOUT with mem_ready low, set fault, drop request, -> HALT.
REQ-012 mem_ready high in first MEM cycle SHALL complete in that cycle (one-cycle access).
REQ-013 JUMP: pc_control=10 for exactly one cycle with instruction unchanged; -> FETCH. Condition evaluation (always / Z=0 / Z=1) belongs to the PC, not this block.
REQ-014 pc_control SHALL be 00 in all cycles other than REQ-007 and REQ-013.
REQ-015 instruction SHALL change only in LATCH.
REQ-016 Cycle cost per instruction: NOP 3, ALU 4, JUMP 4, LOAD/STORE 4+wait cycles, illegal 3.
REQ-017 retired SHALL increment by 1 on leaving DECODE (NOP/illegal), EXEC, MEM (completed), JUMP, and on entering HALT via opcode; saturate at 16'hFFFF, never wrap.
REQ-018 HALT: absorbing; only reset_n exits; start ignored.
REQ-019 start deasserted mid-program SHALL NOT stop execution; it is sampled only in IDLE.

Reset
REQ-020 reset_n=0 at a rising edge SHALL force IDLE, pc_control=00, instruction=16'h0000, alu_en/mem_rd/mem_wr/fault/halted=0, retired=0, wait counter=0, regardless of state (including mid-MEM).
REQ-021 First cycle after reset release SHALL behave as IDLE.

Structure
REQ-022 Opcode constants, state encoding and pc_control codes (HOLD/INC/JUMP) SHALL live in shared package isa_pkg, also used by PC and datapath.
REQ-023 Single module; the memory-wait watchdog MAY be sub-module mem_watchdog (count, clear, expire).

Verification
REQ-024 Reset, start=1, IRAM words {0x0000, 0x1000, 0xF000} -> pc_control=01 three times, alu_en one pulse, halted=1, retired=3, fault=0.
REQ-025 LOAD 0x2000, mem_ready high 3rd MEM cycle -> mem_rd high exactly 3 cycles, retired+1, next FETCH follows.
REQ-026 STORE 0x3000, mem_ready stuck 0, MEM_TIMEOUT=200 -> mem_wr high 200 cycles, then fault=1, halted=1, mem_wr=0.
REQ-027 JUMP 0x4012 -> in JUMP cycle pc_control=10 and instruction=16'h4012; no 01 in same cycle.
REQ-028 Opcode 0x7123 -> fault=1, execution continues, retired+1; reset_n=0 during MEM -> all outputs to reset values next cycle.
